// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: instruction-memory port, decode handshake, redirect
// input and the exported PC/count observation signals.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [31:0] inst_count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc, pc_plus1, inst_count,
    input  imem_ready, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc, pc_plus1, inst_count,
    output imem_ready, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the word-addressed PC, fetches one word at a
// time from instruction memory and holds it for decode until accepted.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_count_q, inst_count_d;

  always_comb begin
    // NOTE: every next-state signal is defaulted to its held value first so no
    // path through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    inst_count_d = inst_count_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ready) begin
          inst_d       = bus.imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          inst_valid_d = 1'b0;
          inst_count_d = inst_count_q + 32'd1;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins: a word returned this cycle is dropped, but a decode
    // handshake completing this cycle still counts.
    if (bus.redirect) begin
      pc_d         = bus.redirect_pc;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = 1'b0;
      state_d      = FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign bus.imem_req   = (state_q == FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc_plus1   = pc_q + 32'd1;
  assign bus.inst_count = inst_count_q;

endmodule
